pwm_axil_ctrl: RTL and testbench



---
 rtl/pwm_pkg.sv | 29 ++
 rtl/pwm_axil_ctrl_if.sv | 45 ++++
 rtl/pwm_axil_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_pwm_axil_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM register-file access path: response codes,
// controller FSM states and the register-file sizing helpers.
package pwm_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_WAIT_W  = 2'd1,
        W_WAIT_AW = 2'd2,
        W_RESP    = 2'd3
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    function automatic int reg_depth(input int num_channels);
        return 2 + 2 * num_channels;
    endfunction

    function automatic int reg_addr_width(input int num_channels);
        return $clog2(reg_depth(num_channels));
    endfunction

endpackage

// File: rtl/pwm_axil_ctrl_if.sv
// AXI4-Lite slave bus bundle between the interconnect and the PWM controller.
interface pwm_axil_ctrl_if #(
    parameter int AXI_ADDR_WIDTH = 8,
    parameter int AXI_DATA_WIDTH = 32
);

    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic                        awvalid;
    logic                        awready;

    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;

    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;

    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic                        arvalid;
    logic                        arready;

    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/pwm_axil_ctrl.sv
// AXI4-Lite slave that turns each bus access into a single-cycle strobe on the
// PWM register file and returns the matching write/read response.
//
// state     | meaning
// W_IDLE    | ready for AW and W
// W_WAIT_W  | address held, waiting for write data
// W_WAIT_AW | data/strobe held, waiting for write address
// W_RESP    | bvalid up until bready
// R_IDLE    | ready for AR
// R_WAIT    | read_en issued, waiting for read_valid
// R_RESP    | rvalid up until rready
module pwm_axil_ctrl
    import pwm_pkg::*;
#(
    parameter  int REG_WIDTH      = 16,
    parameter  int NUM_CHANNELS   = 4,
    parameter  int AXI_ADDR_WIDTH = 8,
    parameter  int AXI_DATA_WIDTH = 32,
    localparam int DEPTH          = reg_depth(NUM_CHANNELS),
    localparam int ADDR_WIDTH     = reg_addr_width(NUM_CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    pwm_axil_ctrl_if.slave        s,
    output logic                  write_en,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [REG_WIDTH-1:0]  write_data,
    output logic                  read_en,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [REG_WIDTH-1:0]  read_data,
    input  logic                  read_valid
);

    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int REG_BYTES  = (REG_WIDTH + 7) / 8;
    localparam logic [STRB_WIDTH-1:0] STRB_REQ = STRB_WIDTH'((1 << REG_BYTES) - 1);

    // Word index below DEPTH also guarantees every upper address bit is zero.
    function automatic logic addr_legal(input logic [AXI_ADDR_WIDTH-1:0] addr);
        logic [AXI_ADDR_WIDTH-1:0] word;
        word = addr >> 2;
        return (addr[1:0] == 2'b00) && (word < AXI_ADDR_WIDTH'(DEPTH));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH+1:2];
    endfunction

    wr_state_t                 wr_state, wr_next;
    rd_state_t                 rd_state, rd_next;

    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_n;
    logic [REG_WIDTH-1:0]      w_data_q, w_data_n;
    logic [STRB_WIDTH-1:0]     w_strb_q, w_strb_n;

    logic                      awready_q, awready_n;
    logic                      wready_q, wready_n;
    logic                      bvalid_q, bvalid_n;
    logic [1:0]                bresp_q, bresp_n;
    logic                      write_en_q, write_en_n;
    logic [ADDR_WIDTH-1:0]     write_addr_q, write_addr_n;
    logic [REG_WIDTH-1:0]      write_data_q, write_data_n;

    logic                      arready_q, arready_n;
    logic                      rvalid_q, rvalid_n;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_n;
    logic [1:0]                rresp_q, rresp_n;
    logic                      read_en_q, read_en_n;
    logic [ADDR_WIDTH-1:0]     read_addr_q, read_addr_n;

    logic                      aw_hs, w_hs, ar_hs;
    logic                      wr_fire, wr_ok;
    logic [AXI_ADDR_WIDTH-1:0] fin_addr;
    logic [REG_WIDTH-1:0]      fin_data;
    logic [STRB_WIDTH-1:0]     fin_strb;

    logic                      unused_wdata;
    assign unused_wdata = ^s.wdata;

    assign aw_hs = s.awvalid && awready_q;
    assign w_hs  = s.wvalid  && wready_q;
    assign ar_hs = s.arvalid && arready_q;

    always_comb begin
        wr_next      = wr_state;
        aw_addr_n    = aw_addr_q;
        w_data_n     = w_data_q;
        w_strb_n     = w_strb_q;
        awready_n    = 1'b0;
        wready_n     = 1'b0;
        bvalid_n     = 1'b0;
        bresp_n      = bresp_q;
        write_en_n   = 1'b0;
        write_addr_n = write_addr_q;
        write_data_n = write_data_q;
        wr_fire      = 1'b0;
        wr_ok        = 1'b0;
        fin_addr     = aw_addr_q;
        fin_data     = w_data_q;
        fin_strb     = w_strb_q;

        case (wr_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_fire  = 1'b1;
                    fin_addr = s.awaddr;
                    fin_data = s.wdata[REG_WIDTH-1:0];
                    fin_strb = s.wstrb;
                end else if (aw_hs) begin
                    aw_addr_n = s.awaddr;
                    wready_n  = 1'b1;
                    wr_next   = W_WAIT_W;
                end else if (w_hs) begin
                    w_data_n  = s.wdata[REG_WIDTH-1:0];
                    w_strb_n  = s.wstrb;
                    awready_n = 1'b1;
                    wr_next   = W_WAIT_AW;
                end else begin
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                end
            end
            W_WAIT_W: begin
                if (w_hs) begin
                    wr_fire  = 1'b1;
                    fin_data = s.wdata[REG_WIDTH-1:0];
                    fin_strb = s.wstrb;
                end else begin
                    wready_n = 1'b1;
                end
            end
            W_WAIT_AW: begin
                if (aw_hs) begin
                    wr_fire  = 1'b1;
                    fin_addr = s.awaddr;
                end else begin
                    awready_n = 1'b1;
                end
            end
            W_RESP: begin
                if (s.bready) begin
                    wr_next   = W_IDLE;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                end else begin
                    bvalid_n = 1'b1;
                end
            end
            default: wr_next = W_IDLE;
        endcase

        if (wr_fire) begin
            wr_ok      = addr_legal(fin_addr) && ((fin_strb & STRB_REQ) == STRB_REQ);
            wr_next    = W_RESP;
            bvalid_n   = 1'b1;
            bresp_n    = wr_ok ? RESP_OKAY : RESP_SLVERR;
            write_en_n = wr_ok;
            if (wr_ok) begin
                write_addr_n = word_index(fin_addr);
                write_data_n = fin_data;
            end
        end
    end

    always_comb begin
        rd_next     = rd_state;
        arready_n   = 1'b0;
        rvalid_n    = 1'b0;
        rdata_n     = rdata_q;
        rresp_n     = rresp_q;
        read_en_n   = 1'b0;
        read_addr_n = read_addr_q;

        case (rd_state)
            R_IDLE: begin
                if (ar_hs) begin
                    if (addr_legal(s.araddr)) begin
                        read_en_n   = 1'b1;
                        read_addr_n = word_index(s.araddr);
                        rd_next     = R_WAIT;
                    end else begin
                        rvalid_n = 1'b1;
                        rdata_n  = '0;
                        rresp_n  = RESP_SLVERR;
                        rd_next  = R_RESP;
                    end
                end else begin
                    arready_n = 1'b1;
                end
            end
            R_WAIT: begin
                if (read_valid) begin
                    rvalid_n = 1'b1;
                    rdata_n  = AXI_DATA_WIDTH'(read_data);
                    rresp_n  = RESP_OKAY;
                    rd_next  = R_RESP;
                end
            end
            R_RESP: begin
                if (s.rready) begin
                    rd_next   = R_IDLE;
                    arready_n = 1'b1;
                end else begin
                    rvalid_n = 1'b1;
                end
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state     <= W_IDLE;
            rd_state     <= R_IDLE;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            read_en_q    <= 1'b0;
            read_addr_q  <= '0;
        end else begin
            wr_state     <= wr_next;
            rd_state     <= rd_next;
            aw_addr_q    <= aw_addr_n;
            w_data_q     <= w_data_n;
            w_strb_q     <= w_strb_n;
            awready_q    <= awready_n;
            wready_q     <= wready_n;
            bvalid_q     <= bvalid_n;
            bresp_q      <= bresp_n;
            write_en_q   <= write_en_n;
            write_addr_q <= write_addr_n;
            write_data_q <= write_data_n;
            arready_q    <= arready_n;
            rvalid_q     <= rvalid_n;
            rdata_q      <= rdata_n;
            rresp_q      <= rresp_n;
            read_en_q    <= read_en_n;
            read_addr_q  <= read_addr_n;
        end
    end

    assign s.awready  = awready_q;
    assign s.wready   = wready_q;
    assign s.bvalid   = bvalid_q;
    assign s.bresp    = bresp_q;
    assign s.arready  = arready_q;
    assign s.rvalid   = rvalid_q;
    assign s.rdata    = rdata_q;
    assign s.rresp    = rresp_q;
    assign write_en   = write_en_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign read_en    = read_en_q;
    assign read_addr  = read_addr_q;

endmodule

// File: tb/tb_pwm_axil_ctrl.sv
// Scoreboard bench for pwm_axil_ctrl with a behavioural register file and model memory.
module tb_pwm_axil_ctrl;
    import pwm_pkg::*;

    localparam int REG_WIDTH      = 16;
    localparam int NUM_CHANNELS   = 4;
    localparam int AXI_ADDR_WIDTH = 8;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int DEPTH          = 2 + 2 * NUM_CHANNELS;
    localparam int ADDR_WIDTH     = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                  write_en;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [REG_WIDTH-1:0]  write_data;
    logic                  read_en;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [REG_WIDTH-1:0]  read_data;
    logic                  read_valid;

    pwm_axil_ctrl_if #(.AXI_ADDR_WIDTH(AXI_ADDR_WIDTH), .AXI_DATA_WIDTH(AXI_DATA_WIDTH)) bus ();

    pwm_axil_ctrl #(
        .REG_WIDTH(REG_WIDTH), .NUM_CHANNELS(NUM_CHANNELS),
        .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH), .AXI_DATA_WIDTH(AXI_DATA_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .s(bus),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .read_en(read_en), .read_addr(read_addr),
        .read_data(read_data), .read_valid(read_valid)
    );

    // Register file stand-in: read returns the value before a same-edge write.
    logic [REG_WIDTH-1:0] rf [DEPTH];
    always @(posedge clk) begin
        if (rst) begin
            read_valid <= 1'b0;
            read_data  <= '0;
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
        end else begin
            read_valid <= read_en;
            if (read_en && int'(read_addr) < DEPTH) read_data <= rf[read_addr];
            if (write_en && int'(write_addr) < DEPTH) rf[write_addr] <= write_data;
        end
    end

    int tests = 0;
    int fails = 0;

    logic [REG_WIDTH-1:0] model_mem [DEPTH];
    logic [1:0]  exp_b  [$];
    logic [33:0] exp_r  [$];
    int          exp_wa [$];
    int          exp_wd [$];
    int          exp_ra [$];
    logic [33:0] mon_r;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void miss(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got unexpected or missing event, expected matching scoreboard entry", name);
    endfunction

    function automatic bit legal(input logic [7:0] addr);
        int a;
        a = int'(addr);
        return (a % 4 == 0) && (a / 4 < DEPTH);
    endfunction

    always @(negedge clk) begin
        if (bus.bvalid === 1'b1 && bus.bready === 1'b1) begin
            if (exp_b.size() == 0) miss("b_unexpected");
            else chk("bresp", 32'(bus.bresp), 32'(exp_b.pop_front()));
        end
        if (bus.rvalid === 1'b1 && bus.rready === 1'b1) begin
            if (exp_r.size() == 0) miss("r_unexpected");
            else begin
                mon_r = exp_r.pop_front();
                chk("rdata", bus.rdata, mon_r[31:0]);
                chk("rresp", 32'(bus.rresp), 32'(mon_r[33:32]));
            end
        end
        if (write_en === 1'b1) begin
            if (exp_wa.size() == 0) miss("write_en_unexpected");
            else begin
                chk("write_addr", 32'(write_addr), exp_wa.pop_front());
                chk("write_data", 32'(write_data), exp_wd.pop_front());
            end
        end
        if (read_en === 1'b1) begin
            if (exp_ra.size() == 0) miss("read_en_unexpected");
            else chk("read_addr", 32'(read_addr), exp_ra.pop_front());
        end
    end

    // mode 0: AW and W together, 1: W first, 2: AW first; gap cycles between them.
    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int mode, input int gap, input int hold);
        bit ok, aw_done, w_done, af, wf;
        int cnt;
        logic [1:0] er;
        ok = legal(addr) && (strb[1:0] == 2'b11);
        er = ok ? RESP_OKAY : RESP_SLVERR;
        exp_b.push_back(er);
        if (ok) begin
            exp_wa.push_back(int'(addr) / 4);
            exp_wd.push_back(int'(data[15:0]));
            model_mem[int'(addr) / 4] = data[15:0];
        end
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = (mode != 1);
        bus.wvalid  = (mode != 2);
        aw_done = 0; w_done = 0; cnt = 0;
        while (!(aw_done && w_done)) begin
            @(negedge clk);
            af = bus.awvalid && bus.awready;
            wf = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            if (af) begin bus.awvalid = 1'b0; aw_done = 1; end
            if (wf) begin bus.wvalid = 1'b0; w_done = 1; end
            if ((aw_done ^ w_done) && !bus.awvalid && !bus.wvalid) begin
                repeat (gap) @(posedge clk);
                #1;
                chk("wait_readies", {30'd0, bus.awready, bus.wready}, w_done ? 32'b10 : 32'b01);
                bus.awvalid = !aw_done;
                bus.wvalid  = !w_done;
            end
            cnt++;
            if (cnt > 50) begin
                miss("w_handshake_timeout");
                bus.awvalid = 1'b0;
                bus.wvalid  = 1'b0;
                return;
            end
        end
        chk("b_latency", 32'(bus.bvalid), 32'd1);
        chk("w_blocked", {30'd0, bus.awready, bus.wready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("b_hold", {27'd0, bus.bvalid, bus.bresp, bus.awready, bus.wready}, {27'd0, 1'b1, er, 2'b00});
        end
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] addr, input int hold);
        bit ok, af;
        int cnt;
        logic [33:0] er;
        ok = legal(addr);
        if (ok) begin
            exp_ra.push_back(int'(addr) / 4);
            er = {RESP_OKAY, 16'h0, model_mem[int'(addr) / 4]};
        end else begin
            er = {RESP_SLVERR, 32'h0};
        end
        exp_r.push_back(er);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        af = 0; cnt = 0;
        while (!af) begin
            @(negedge clk);
            af = bus.arvalid && bus.arready;
            @(posedge clk); #1;
            cnt++;
            if (!af && cnt > 50) begin
                miss("ar_handshake_timeout");
                bus.arvalid = 1'b0;
                return;
            end
        end
        bus.arvalid = 1'b0;
        cnt = 0;
        while (!bus.rvalid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("r_latency", cnt, ok ? 32'd2 : 32'd0);
        chk("ar_blocked", 32'(bus.arready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("r_hold_ctl", {28'd0, bus.rvalid, bus.arready, bus.rresp}, {28'd0, 1'b1, 1'b0, er[33:32]});
            chk("r_hold_data", bus.rdata, er[31:0]);
        end
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
    endtask

    function automatic logic [7:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel <= 6)      return 8'($urandom_range(0, DEPTH - 1) * 4);
        else if (sel == 7) return 8'($urandom_range(DEPTH, 15) * 4);
        else if (sel == 8) return 8'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        else               return 8'($urandom_range(16, 63) * 4);
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd0);
        chk("reset_valids", {28'd0, bus.bvalid, bus.rvalid, write_en, read_en}, 32'd0);
        chk("reset_payload", {28'd0, bus.bresp, bus.rresp}, 32'd0);
        chk("reset_rdata", bus.rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'b111);

        do_write(8'h04, 32'hABCD_1234, 4'hF, 0, 0, 0);
        do_read(8'h04, 0);
        do_write(8'h08, 32'h0000_00FF, 4'hF, 1, 3, 0);
        do_write(8'h0C, 32'h0000_5A5A, 4'hF, 2, 3, 1);
        do_read(8'h08, 1);
        do_read(8'h0C, 0);
        do_write(8'h28, 32'h0000_1111, 4'hF, 0, 0, 0);
        do_write(8'h05, 32'h0000_2222, 4'hF, 0, 0, 0);
        do_read(8'h28, 0);
        do_write(8'h00, 32'h0000_3333, 4'h1, 0, 0, 0);
        do_read(8'h00, 0);
        do_write(8'h24, 32'h0000_BEEF, 4'hF, 0, 0, 10);
        do_read(8'h24, 10);

        // Abort a write waiting for data and a read waiting for read_valid.
        exp_ra.push_back(3);
        bus.awaddr = 8'h0C; bus.awvalid = 1'b1;
        bus.araddr = 8'h0C; bus.arvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        chk("pre_rst_state", {29'd0, bus.awready, bus.wready, read_en}, 32'b011);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_valids", {28'd0, bus.bvalid, bus.rvalid, write_en, read_en}, 32'd0);
        chk("rst_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        @(posedge clk); #1;
        chk("rst_idle_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'b111);
        do_write(8'h10, 32'h0000_C0DE, 4'hF, 0, 0, 0);
        do_read(8'h10, 0);
        do_read(8'h0C, 0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(rand_addr(), $urandom(),
                         ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15)),
                         $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(rand_addr(), $urandom_range(0, 3));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("left_b", exp_b.size(), 32'd0);
        chk("left_r", exp_r.size(), 32'd0);
        chk("left_wr", exp_wa.size(), 32'd0);
        chk("left_rd", exp_ra.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
